// File: rtl/dmem_rmw_ctrl.sv
// dmem_rmw_ctrl: CPU data-memory access controller with sub-word load extension and read-modify-write for sh/sb.
module dmem_rmw_ctrl #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_access,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_e;
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, word_q, word_d;
  logic [3:0]  acc_q, acc_d;
  logic        err_q, err_d;
  logic        req_err;
  logic [4:0]  sh;
  logic [15:0] half;
  logic [7:0]  byt;
  logic [31:0] ld;
  assign req_err = !(req_access inside {[4'd1:4'd8]})
                || ((req_access == 4'd1 || req_access == 4'd6) && req_addr[1:0] != 2'b00)
                || ((req_access == 4'd2 || req_access == 4'd4 || req_access == 4'd7) && req_addr[0]);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    acc_d   = acc_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        acc_d   = req_access;
        err_d   = req_err;
        state_d = req_err ? RESP : req_access == 4'd6 ? WR : RD;
      end
      RD: begin
        cnt_d   = 3'(READ_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          word_d  = mem_rdata;
          state_d = acc_q >= 4'd7 ? WR : RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Sub-word lane selected by the latched byte offset; shared by load extraction and byte merge.
  assign sh   = {addr_q[1:0], 3'b000};
  assign half = addr_q[1] ? word_q[31:16] : word_q[15:0];
  assign byt  = 8'(word_q >> sh);
  assign ld   = acc_q == 4'd1 ? word_q
              : acc_q == 4'd2 ? {{16{half[15]}}, half}
              : acc_q == 4'd3 ? {{24{byt[7]}}, byt}
              : acc_q == 4'd4 ? {16'h0, half}
              : {24'h0, byt};
  assign req_ready  = state_q == IDLE;
  assign mem_re     = state_q == RD;
  assign mem_we     = state_q == WR;
  assign resp_valid = state_q == RESP;
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && acc_q <= 4'd5) ? ld : 32'h0;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = acc_q == 4'd6 ? wdata_q
                    : acc_q == 4'd7 ? (addr_q[1] ? {wdata_q[15:0], word_q[15:0]} : {word_q[31:16], wdata_q[15:0]})
                    : (word_q & ~(32'hFF << sh)) | (32'(wdata_q[7:0]) << sh);
endmodule
